// File: rtl/dpll_pkg.sv
// Shared DPLL definitions: default divider settings, pend width helper and the
// correction codes exchanged between loop filter, phase detector and DCO.
package dpll_pkg;

  localparam int DIV_N_DEF    = 16;
  localparam int MAX_PEND_DEF = 3;

  localparam logic [1:0] CORR_NONE = 2'd0;
  localparam logic [1:0] CORR_ADV  = 2'd1;
  localparam logic [1:0] CORR_RET  = 2'd2;

  // Two's-complement width able to hold -max_pend .. +max_pend.
  function automatic int pend_width(input int max_pend);
    return $clog2(max_pend + 1) + 1;
  endfunction

endpackage

// File: rtl/dpll_dco_if.sv
// Loop-filter to DCO link: correction requests in, recovered timing pulses out.
interface dpll_dco_if;

  logic add;
  logic sub;
  logic dco_clk;
  logic strobe;
  logic wrap;
  logic corr_adv;
  logic corr_ret;
  logic ovf;

  modport master (
    output add, sub,
    input  dco_clk, strobe, wrap, corr_adv, corr_ret, ovf
  );

  modport slave (
    input  add, sub,
    output dco_clk, strobe, wrap, corr_adv, corr_ret, ovf
  );

endinterface

// File: rtl/dpll_pend_acc.sv
// Saturating signed accumulator of pending period corrections; consumption is
// applied before the new request so a saturated value drops the request.
module dpll_pend_acc
  import dpll_pkg::*;
#(
  parameter int MAX_PEND = MAX_PEND_DEF,
  parameter int PEND_W   = pend_width(MAX_PEND)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     add,
  input  logic                     sub,
  input  logic                     consume_up,
  input  logic                     consume_dn,
  output logic signed [PEND_W-1:0] pend,
  output logic                     ovf
);

  localparam logic signed [PEND_W-1:0] PMAX    = PEND_W'(MAX_PEND);
  localparam logic signed [PEND_W-1:0] PMIN    = -PMAX;
  localparam logic signed [PEND_W-1:0] PEND_ONE = PEND_W'(1);

  logic signed [PEND_W-1:0] pend_r;
  logic signed [PEND_W-1:0] base_s;
  logic signed [PEND_W-1:0] pend_next_s;
  logic                     ovf_r;
  logic                     ovf_next_s;

  // Next accumulator value: consume toward zero, then apply the net request.
  always_comb begin
    base_s      = pend_r;
    pend_next_s = pend_r;
    ovf_next_s  = 1'b0;
    if (consume_up) begin
      base_s = pend_r + PEND_ONE;
    end else if (consume_dn) begin
      base_s = pend_r - PEND_ONE;
    end else begin
      base_s = pend_r;
    end
    case ({add, sub})
      2'b10: begin
        if (base_s >= PMAX) begin
          pend_next_s = base_s;
          ovf_next_s  = 1'b1;
        end else begin
          pend_next_s = base_s + PEND_ONE;
        end
      end
      2'b01: begin
        if (base_s <= PMIN) begin
          pend_next_s = base_s;
          ovf_next_s  = 1'b1;
        end else begin
          pend_next_s = base_s - PEND_ONE;
        end
      end
      default: pend_next_s = base_s;
    endcase
  end

  // Accumulator and overflow pulse registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_r <= '0;
      ovf_r  <= 1'b0;
    end else begin
      pend_r <= pend_next_s;
      ovf_r  <= ovf_next_s;
    end
  end

  assign pend = pend_r;
  assign ovf  = ovf_r;

endmodule

// File: rtl/dpll_dco.sv
// DPLL DCO: divides clk by DIV_N, shortening or lengthening single periods by
// one cycle as pending loop-filter corrections are consumed at period wrap.
module dpll_dco
  import dpll_pkg::*;
#(
  parameter int DIV_N    = DIV_N_DEF,
  parameter int MAX_PEND = MAX_PEND_DEF
) (
  input  logic       clk,
  input  logic       rst_n,
  dpll_dco_if.slave  bus
);

  localparam int CNT_W  = $clog2(DIV_N + 2);
  localparam int HALF   = DIV_N / 2;
  localparam int PEND_W = pend_width(MAX_PEND);

  localparam logic [CNT_W-1:0] LEN_NOM = CNT_W'(DIV_N);
  localparam logic [CNT_W-1:0] LEN_ADV = CNT_W'(DIV_N - 1);
  localparam logic [CNT_W-1:0] LEN_RET = CNT_W'(DIV_N + 1);
  localparam logic [CNT_W-1:0] HALF_C  = CNT_W'(HALF);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic signed [PEND_W-1:0] PEND_ZERO = PEND_W'(0);

  logic [CNT_W-1:0]         cnt_r;
  logic [CNT_W-1:0]         len_r;
  logic [CNT_W-1:0]         len_next_s;
  logic signed [PEND_W-1:0] pend_s;
  logic                     ovf_s;
  logic                     terminal_s;
  logic                     add_s;
  logic                     sub_s;
  logic                     consume_up_s;
  logic                     consume_dn_s;
  logic [1:0]               corr_sel_s;
  logic                     dco_clk_r;
  logic                     strobe_r;
  logic                     wrap_r;
  logic                     corr_adv_r;
  logic                     corr_ret_r;

  // Terminal detection and choice of the next period length from the old pend.
  always_comb begin
    add_s      = rst_n & bus.add;
    sub_s      = rst_n & bus.sub;
    terminal_s = (cnt_r == (len_r - ONE_C));
    if (terminal_s && (pend_s > PEND_ZERO)) begin
      corr_sel_s = CORR_ADV;
    end else if (terminal_s && (pend_s < PEND_ZERO)) begin
      corr_sel_s = CORR_RET;
    end else begin
      corr_sel_s = CORR_NONE;
    end
    case (corr_sel_s)
      CORR_ADV:  len_next_s = LEN_ADV;
      CORR_RET:  len_next_s = LEN_RET;
      CORR_NONE: len_next_s = LEN_NOM;
      default:   len_next_s = LEN_NOM;
    endcase
    consume_dn_s = (corr_sel_s == CORR_ADV);
    consume_up_s = (corr_sel_s == CORR_RET);
  end

  dpll_pend_acc #(
    .MAX_PEND (MAX_PEND),
    .PEND_W   (PEND_W)
  ) u_acc (
    .clk        (clk),
    .rst_n      (rst_n),
    .add        (add_s),
    .sub        (sub_s),
    .consume_up (consume_up_s),
    .consume_dn (consume_dn_s),
    .pend       (pend_s),
    .ovf        (ovf_s)
  );

  // Phase counter, period length and registered timing outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_r      <= '0;
      len_r      <= LEN_NOM;
      dco_clk_r  <= 1'b0;
      strobe_r   <= 1'b0;
      wrap_r     <= 1'b0;
      corr_adv_r <= 1'b0;
      corr_ret_r <= 1'b0;
    end else begin
      dco_clk_r  <= (cnt_r < HALF_C);
      strobe_r   <= (cnt_r == HALF_C);
      wrap_r     <= terminal_s;
      corr_adv_r <= consume_dn_s;
      corr_ret_r <= consume_up_s;
      if (terminal_s) begin
        cnt_r <= '0;
        len_r <= len_next_s;
      end else begin
        cnt_r <= cnt_r + ONE_C;
      end
    end
  end

  assign bus.dco_clk  = dco_clk_r;
  assign bus.strobe   = strobe_r;
  assign bus.wrap     = wrap_r;
  assign bus.corr_adv = corr_adv_r;
  assign bus.corr_ret = corr_ret_r;
  assign bus.ovf      = ovf_s;

endmodule

// File: tb/tb_dpll_dco.sv
// Bench for dpll_dco: period-level reference model checked every cycle, plus
// directed period-length scenarios with literal expectations and random traffic.
module tb_dpll_dco;

  localparam int DIV_N    = 16;
  localparam int MAX_PEND = 3;
  localparam int HALF     = DIV_N / 2;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  dpll_dco_if bus ();

  dpll_dco #(.DIV_N(DIV_N), .MAX_PEND(MAX_PEND)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    int ph;   // position within current period
    int ln;   // length of current period
    int pd;   // pending corrections
    bit ea;
    bit er;
    bit eo;
  } mstate_t;

  mstate_t m;
  logic    e_dco, e_strobe, e_wrap;
  bit      m_valid = 1'b0;

  function automatic mstate_t step(input mstate_t cur, input logic a, input logic s);
    mstate_t n;
    n    = cur;
    n.ea = 1'b0;
    n.er = 1'b0;
    n.eo = 1'b0;
    if (cur.ph == cur.ln - 1) begin
      n.ph = 0;
      if (cur.pd > 0) begin
        n.ln = DIV_N - 1; n.pd = cur.pd - 1; n.ea = 1'b1;
      end else if (cur.pd < 0) begin
        n.ln = DIV_N + 1; n.pd = cur.pd + 1; n.er = 1'b1;
      end else begin
        n.ln = DIV_N;
      end
    end else begin
      n.ph = cur.ph + 1;
    end
    if (a && !s) begin
      if (n.pd == MAX_PEND) n.eo = 1'b1; else n.pd = n.pd + 1;
    end else if (s && !a) begin
      if (n.pd == -MAX_PEND) n.eo = 1'b1; else n.pd = n.pd - 1;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    m_valid <= 1'b1;
    if (!rst_n) begin
      m        <= '{ph: 0, ln: DIV_N, pd: 0, ea: 1'b0, er: 1'b0, eo: 1'b0};
      e_dco    <= 1'b0;
      e_strobe <= 1'b0;
      e_wrap   <= 1'b0;
    end else begin
      e_dco    <= (m.ph < HALF);
      e_strobe <= (m.ph == HALF);
      e_wrap   <= (m.ph == m.ln - 1);
      m        <= step(m, bus.add, bus.sub);
    end
  end

  task automatic chk(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got %b expected %b", nm, $time, act, exp);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (m_valid) begin
      chk("dco_clk",  bus.dco_clk,  e_dco);
      chk("strobe",   bus.strobe,   e_strobe);
      chk("wrap",     bus.wrap,     e_wrap);
      chk("corr_adv", bus.corr_adv, m.ea);
      chk("corr_ret", bus.corr_ret, m.er);
      chk("ovf",      bus.ovf,      m.eo);
    end
  end

  bit sa [0:127];
  bit sr [0:127];
  int per [0:7];
  int ovf_cnt;
  int sidx, widx, hi;

  task automatic clear_sched();
    for (int i = 0; i < 128; i++) begin
      sa[i] = 1'b0;
      sr[i] = 1'b0;
    end
  endtask

  // Start at a wrap negedge; drive schedule by offset and record n period lengths.
  task automatic run_sched(input int n);
    int k, last, got;
    k = 0; last = 0; got = 0; ovf_cnt = 0;
    while (got < n && k < 120) begin
      bus.add = sa[k];
      bus.sub = sr[k];
      @(negedge clk);
      k++;
      if (bus.ovf) ovf_cnt++;
      if (bus.wrap) begin
        per[got] = k - last;
        last = k;
        got++;
      end
    end
    bus.add = 1'b0;
    bus.sub = 1'b0;
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL period_timeout got %0d periods expected %0d", got, n);
    end
  endtask

  initial begin
    bus.add = 1'b0;
    bus.sub = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_dco", bus.dco_clk, 1'b0);
    chk("reset_wrap", bus.wrap, 1'b0);
    rst_n = 1'b1;

    // Nominal start-up waveform.
    sidx = 0; widx = 0; hi = 0;
    for (int k = 1; k <= DIV_N; k++) begin
      @(negedge clk);
      if (k == 1) chk("first_rise", bus.dco_clk, 1'b1);
      if (bus.strobe && sidx == 0) sidx = k;
      if (bus.wrap && widx == 0) widx = k;
      if (bus.dco_clk) hi++;
    end
    chk_int("first_strobe", sidx, 9);
    chk_int("first_wrap", widx, 16);
    chk_int("high_cycles", hi, 8);
    clear_sched();
    run_sched(2);
    chk_int("nom_p0", per[0], 16);
    chk_int("nom_p1", per[1], 16);

    // Single add.
    clear_sched(); sa[4] = 1'b1; run_sched(3);
    chk_int("add_p0", per[0], 16);
    chk_int("add_p1", per[1], 15);
    chk_int("add_p2", per[2], 16);

    // Single sub, then add+sub cancelling.
    clear_sched(); sr[4] = 1'b1; run_sched(3);
    chk_int("sub_p0", per[0], 16);
    chk_int("sub_p1", per[1], 17);
    chk_int("sub_p2", per[2], 16);
    clear_sched(); sa[4] = 1'b1; sr[4] = 1'b1; run_sched(2);
    chk_int("cancel_p0", per[0], 16);
    chk_int("cancel_p1", per[1], 16);

    // Burst of five adds saturates at MAX_PEND.
    clear_sched();
    for (int i = 2; i <= 6; i++) sa[i] = 1'b1;
    run_sched(5);
    chk_int("burst_ovf", ovf_cnt, 2);
    chk_int("burst_p0", per[0], 16);
    chk_int("burst_p1", per[1], 15);
    chk_int("burst_p2", per[2], 15);
    chk_int("burst_p3", per[3], 15);
    chk_int("burst_p4", per[4], 16);

    // Add on the terminal cycle only affects the period after next.
    clear_sched(); sa[15] = 1'b1; run_sched(4);
    chk_int("term_p0", per[0], 16);
    chk_int("term_p1", per[1], 16);
    chk_int("term_p2", per[2], 15);
    chk_int("term_p3", per[3], 16);

    // Reset mid-period with two corrections pending.
    clear_sched(); sa[1] = 1'b1; sa[3] = 1'b1;
    for (int k = 0; k < 6; k++) begin
      bus.add = sa[k];
      @(negedge clk);
    end
    bus.add = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_dco", bus.dco_clk, 1'b0);
    chk("rst_strobe", bus.strobe, 1'b0);
    chk("rst_wrap", bus.wrap, 1'b0);
    chk("rst_adv", bus.corr_adv, 1'b0);
    chk("rst_ret", bus.corr_ret, 1'b0);
    chk("rst_ovf", bus.ovf, 1'b0);
    rst_n = 1'b1;
    clear_sched();
    run_sched(3);
    chk_int("rst_p0", per[0], 16);
    chk_int("rst_p1", per[1], 16);
    chk_int("rst_p2", per[2], 16);

    // Random traffic with alternating add-heavy / sub-heavy phases and rare resets.
    for (int c = 0; c < 900; c++) begin
      if ((c / 150) % 2 == 0) begin
        bus.add = ($urandom_range(0, 2) == 0);
        bus.sub = ($urandom_range(0, 9) == 0);
      end else begin
        bus.add = ($urandom_range(0, 9) == 0);
        bus.sub = ($urandom_range(0, 2) == 0);
      end
      rst_n = ($urandom_range(0, 249) != 0);
      @(negedge clk);
    end
    bus.add = 1'b0;
    bus.sub = 1'b0;
    rst_n   = 1'b1;
    repeat (2) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dpll_dco.md
Name: dpll_dco

Overview:
- Digitally controlled oscillator / increment-decrement counter stage of the DPLL.
- Sits directly downstream of the loop filter and consumes its one-cycle add/sub correction pulses.
- Divides the system clock by a nominal DIV_N. Each add pulse shortens one output period by one clk cycle; each sub pulse lengthens one period by one clk cycle.
- Produces the recovered clock, a mid-period sample strobe for the data path, and a period-wrap pulse that feeds back to the phase detector.

Parameters:
- DIV_N, 16: nominal output period in clk cycles; even, >= 4.
- MAX_PEND, 3: saturation magnitude of the pending-correction accumulator; >= 1.
- Derived localparams: CNT_W = clog2(DIV_N+2); HALF = DIV_N/2; PEND_W sized to hold -MAX_PEND..+MAX_PEND signed.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-low.
- add  in  1  one-cycle advance request from loop filter.
- sub  in  1  one-cycle retard request from loop filter.
- dco_clk  out  1  recovered clock, registered.
- strobe  out  1  one-cycle pulse at the mid-period sample point.
- wrap  out  1  one-cycle pulse on the last cycle of each period.
- corr_adv  out  1  one-cycle pulse: the period just started is shortened.
- corr_ret  out  1  one-cycle pulse: the period just started is lengthened.
- ovf  out  1  one-cycle pulse: a request was dropped because the accumulator is saturated.

Behaviour:
- Reset (rst_n low at a clk edge):
  - cnt=0, len=DIV_N, pend=0.
  - All outputs 0.
  - Reset mid-period discards pending corrections; the first period after release is nominal.
- Phase counter cnt:
  - Increments each cycle.
  - When cnt == len-1 (terminal): cnt<=0 and len is reloaded for the next period.
- Period length at terminal, using pend before this cycle's update:
  - pend>0: len<=DIV_N-1, corr_adv<=1, pend consumes one unit (-1).
  - pend<0: len<=DIV_N+1, corr_ret<=1, pend consumes one unit (+1).
  - pend==0: len<=DIV_N.
- Accumulator update each cycle:
  - pend_next = pend + add - sub - consumed, then saturate to [-MAX_PEND, +MAX_PEND].
  - add and sub in the same cycle cancel: no change, no ovf.
  - An add while pend==+MAX_PEND (after consumption) is dropped and ovf<=1. Same for sub at -MAX_PEND.
  - Only one unit is consumed per period, so a burst of requests spreads over successive periods.
- Registered outputs, each updated at every edge from the current cnt:
  - dco_clk <= (cnt < HALF).
  - strobe <= (cnt == HALF).
  - wrap <= (cnt == len-1).
  - All outputs lag cnt by one cycle.
- Output waveforms:
  - Nominal period: dco_clk high HALF, low HALF.
  - Advanced period: high HALF, low HALF-1.
  - Retarded period: high HALF, low HALF+1.
  - The high phase and strobe position are always HALF relative to period start.
- Simultaneous add/sub at the terminal cycle: the correction for the new period uses the old pend; the incoming request affects later periods only.
- X-safety: add/sub are sampled only when rst_n is high.

Decomposition:
- Package dpll_pkg holds:
  - Default DIV_N and MAX_PEND.
  - The signed pend type width function.
  - Correction encoding constants (CORR_NONE/ADV/RET), shared with the loop filter and the phase detector.
- One natural sub-module: dpll_pend_acc, the saturating signed accumulator (inputs add, sub, consume_up, consume_dn; outputs pend, ovf).
- The counter and output registers stay in dpll_dco.

Test Plan:
1. Release reset, no add/sub, DIV_N=16 → dco_clk rises at edge 1, period exactly 16 (8 high/8 low); strobe at cycles 9, 25, …; wrap at cycles 16, 32, …; corr_* and ovf stay 0.
2. Single add pulse mid-period → next period is 15 cycles (8 high/7 low) with corr_adv pulse on its first cycle; the following period returns to 16.
3. Single sub pulse → next period 17 cycles (8/9) with corr_ret; add and sub in the same cycle → no change to any period length.
4. Five consecutive add pulses, MAX_PEND=3 → pend saturates at 3 and ovf pulses twice; the next three periods are 15 cycles each, then 16.
5. add pulse coincident with the terminal cycle while pend=0 → the period starting next is 16 (not 15); the one after is 15.
6. Assert rst_n low for one cycle mid-period with pend=2 → all outputs 0 the next cycle, pend=0, and the subsequent periods are nominal 16.
